emblem_compositor: RTL

//  Final pixel stage: merges pattern background, emblem overlay and text foreground into the TinyTapeout VGA PMOD byte.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/emblem_reveal_ctrl.sv | 87 ++++++++
 rtl/emblem_compositor.sv | 73 +++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: colour constants, emblem geometry, wipe FSM encoding
// and the TinyTapeout VGA PMOD pin packing.
package vga_pkg;

    // Colours are packed {R1,G1,B1,R0,G0,B0}
    localparam logic [5:0] BLACK = 6'b000000;
    localparam logic [5:0] GOLD  = 6'b110110;
    localparam logic [5:0] WHITE = 6'b111111;
    localparam logic [5:0] RED   = 6'b100100;

    localparam int EMBLEM_Y0 = 144;
    localparam int EMBLEM_H  = 160;
    localparam int WIPE_STEP = 4;

    typedef enum logic [1:0] {
        ST_HIDDEN  = 2'd0,
        ST_REVEAL  = 2'd1,
        ST_SHOWN   = 2'd2,
        ST_CONCEAL = 2'd3
    } emblem_state_e;

    // PMOD pin order is {hsync,B0,G0,R0,vsync,B1,G1,R1}
    function automatic logic [7:0] pack_pmod(input logic hs, input logic vs,
                                             input logic [5:0] rgb);
        return {hs, rgb[0], rgb[1], rgb[2], vs, rgb[3], rgb[4], rgb[5]};
    endfunction

endpackage

// File: rtl/emblem_reveal_ctrl.sv
// Frame-stepped wipe FSM: grows reveal_line top-down while the emblem is
// requested and shrinks it back to zero when the request drops.
module emblem_reveal_ctrl
    import vga_pkg::*;
#(
    parameter int EMBLEM_H  = vga_pkg::EMBLEM_H,
    parameter int WIPE_STEP = vga_pkg::WIPE_STEP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       emblem_req,
    output logic [1:0] emblem_state,
    output logic [7:0] reveal_line
);

    localparam logic [8:0] H9    = 9'(EMBLEM_H);
    localparam logic [8:0] STEP9 = 9'(WIPE_STEP);
    localparam logic [7:0] INIT_LINE = (STEP9 >= H9) ? H9[7:0] : STEP9[7:0];
    localparam logic [7:0] DROP_LINE = (H9 > STEP9) ? 8'(H9 - STEP9) : 8'd0;

    emblem_state_e state_q;
    logic [7:0]    line_q;

    // One extra bit so neither direction can wrap before the clamp.
    logic [8:0] sum9;
    logic [8:0] diff9;
    logic       up_full;
    logic       dn_empty;
    logic [7:0] line_up;
    logic [7:0] line_dn;

    assign sum9     = {1'b0, line_q} + STEP9;
    assign diff9    = {1'b0, line_q} - STEP9;
    assign up_full  = (sum9 >= H9);
    assign dn_empty = diff9[8] || (diff9 == 9'd0);
    assign line_up  = up_full  ? H9[7:0] : sum9[7:0];
    assign line_dn  = dn_empty ? 8'd0    : diff9[7:0];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HIDDEN;
            line_q  <= 8'd0;
        end else if (frame_start) begin
            case (state_q)
                ST_HIDDEN: begin
                    if (emblem_req) begin
                        state_q <= ST_REVEAL;
                        line_q  <= INIT_LINE;
                    end
                end
                ST_REVEAL: begin
                    if (!emblem_req) begin
                        state_q <= ST_CONCEAL;
                    end else begin
                        line_q <= line_up;
                        if (up_full) state_q <= ST_SHOWN;
                    end
                end
                ST_SHOWN: begin
                    if (!emblem_req) begin
                        state_q <= ST_CONCEAL;
                        line_q  <= DROP_LINE;
                    end
                end
                ST_CONCEAL: begin
                    if (emblem_req) begin
                        state_q <= ST_REVEAL;
                    end else begin
                        line_q <= line_dn;
                        if (dn_empty) state_q <= ST_HIDDEN;
                    end
                end
                default: begin
                    state_q <= ST_HIDDEN;
                    line_q  <= 8'd0;
                end
            endcase
        end
    end

    assign emblem_state = state_q;
    assign reveal_line  = line_q;

endmodule

// File: rtl/emblem_compositor.sv
// Final pixel stage: text over emblem over background, packed onto the VGA
// PMOD pins through one register stage shared by colour and syncs.
module emblem_compositor
    import vga_pkg::*;
#(
    parameter int EMBLEM_Y0 = vga_pkg::EMBLEM_Y0,
    parameter int EMBLEM_H  = vga_pkg::EMBLEM_H,
    parameter int WIPE_STEP = vga_pkg::WIPE_STEP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       active,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [5:0] bg_rgb,
    input  logic       emblem_draw,
    input  logic [5:0] emblem_rgb,
    input  logic       text_draw,
    input  logic [5:0] text_rgb,
    input  logic       emblem_req,
    output logic [7:0] uo_out,
    output logic [1:0] emblem_state
);

    localparam logic [9:0] Y0_10 = 10'(EMBLEM_Y0);

    logic [7:0] reveal_line;
    logic [9:0] y_off;
    logic       emblem_vis;
    logic [5:0] pix_rgb;
    logic [7:0] uo_out_q;
    logic       unused_x;

    // Column is not needed here; coverage already arrives as draw flags.
    assign unused_x = ^x;

    emblem_reveal_ctrl #(
        .EMBLEM_H  (EMBLEM_H),
        .WIPE_STEP (WIPE_STEP)
    ) u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .emblem_req   (emblem_req),
        .emblem_state (emblem_state),
        .reveal_line  (reveal_line)
    );

    assign y_off      = y - Y0_10;
    assign emblem_vis = emblem_draw && (y >= Y0_10) && (y_off < {2'b00, reveal_line});

    // NOTE: pix_rgb gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        pix_rgb = BLACK;
        if (active) begin
            if (text_draw)       pix_rgb = text_rgb;
            else if (emblem_vis) pix_rgb = emblem_rgb;
            else                 pix_rgb = bg_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) uo_out_q <= 8'h00;
        else       uo_out_q <= pack_pmod(hsync, vsync, pix_rgb);
    end

    assign uo_out = uo_out_q;

endmodule
